dice_roll_arbiter: RTL and testbench
====================================

Name: dice_roll_arbiter

Overview:
- Shares one 3-bit dice-face sequence counter between two requesters.
- The face walks the fixed order 1→6→2→3→4→5→1.
- Per roll:
  - Round-robin arbitrates between requesters.
  - Runs the counter for a pseudo-random number of steps, drawn from a free-running LFSR.
  - Returns the final face to the winner with a one-cycle acknowledge.
- Sits between player/control logic and the display/score path.

Parameters:
- LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR. Must be nonzero.
- MIN_STEPS, 4, minimum counter advances per roll. Range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  level request per requester; held until ack or withdrawn.
- ack  output  2  one-hot, one-cycle pulse to the requester whose roll completed.
- face  output  3  current counter face (1..6); holds the last result between rolls.
- face_valid  output  1  high for the same cycle as ack; face is the roll result.
- winner  output  1  index of the last acknowledged requester.
- busy  output  1  high in ROLL and DONE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: sampled on the rising clk edge, overrides all other inputs, including mid-roll (roll discarded, no ack).
- Reset values:
  - state=IDLE, face=3'd1, lfsr=LFSR_SEED.
  - ack=2'b00, face_valid=0, busy=0.
  - winner=1, so requester 0 wins the first tie.
  - steps=0, grant=0.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every cycle when not in reset, in every state.
- Face advance, one per ROLL cycle: 1→6, 6→2, 2→3, 3→4, 4→5, 5→1. Illegal values 0 or 7 advance to 1.
- IDLE (busy=0):
  - If req!=0, arbitrate:
    - Single request wins.
    - Both high: requester !winner wins.
  - On the arbitration edge: grant<=winner index, steps<=MIN_STEPS+lfsr[3:0] (5-bit, no overflow: max 30), state<=ROLL.
  - If req==0, stay in IDLE.
- ROLL (busy=1):
  - Each cycle: face advances, steps decrements.
  - When steps==1 on an edge: final advance, state<=DONE.
  - Exactly `steps` advances per roll.
  - If req[grant] is low in a ROLL cycle, abort:
    - No advance that edge; state<=IDLE.
    - face keeps its current value; no ack; winner unchanged.
  - The other requester's req is ignored during ROLL.
- DONE (busy=1), one cycle:
  - ack[grant]=1 and face_valid=1 (Moore decode of state).
  - On exit edge: winner<=grant, state<=IDLE.
- Latency: request sampled in IDLE at cycle T → ack at cycle T+1+steps.
- Requester protocol:
  - Requester drops req on the edge after seeing ack.
  - req still high in the following IDLE cycle counts as a new request.
- Back-to-back: with both requesters asserting continuously, grants alternate 0,1,0,1...
- face changes only in ROLL and on reset. It is stable in IDLE and DONE.

Test Plan:
- Reset release, req=2'b01 from the first cycle (lfsr=8'hA5):
  - steps=4+5=9.
  - ack=2'b01 and face_valid=1 exactly 10 cycles later.
  - face=3: nine advances from 1 along 1,6,2,3,4,5.
  - busy high for those 10 cycles.
- Both req high continuously for 4 rolls → ack order 01,10,01,10. winner toggles after each DONE. No cycle with both ack bits set.
- Granted requester drops req mid-ROLL → state returns to IDLE the next edge, no ack, face frozen at its mid-roll value, winner unchanged. Pending other req then granted.
- Reset asserted during ROLL → next cycle face=1, busy=0, ack=0, lfsr=8'hA5, winner=1.
- Scoreboard, 1000 random rolls: reference LFSR/step model predicts every result. Check:
  - face ∈ 1..6 always.
  - face constant outside ROLL.
  - ack latency = steps+1.
- MIN_STEPS=1 build, lfsr[3:0]=0 at grant:
  - one ROLL cycle; ack 2 cycles after the request.
  - face advanced exactly once, e.g. 5→1.

Source files
------------

// File: rtl/dice_roll_arbiter_if.sv
// ============================================================================
// Module      : dice_roll_arbiter_if
// Description : Requester-side bundle for the dice roll arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dice_roll_arbiter_if;
    logic [1:0] req;
    logic [1:0] ack;
    logic [2:0] face;
    logic       face_valid;
    logic       winner;
    logic       busy;

    modport master (
        output req,
        input  ack,
        input  face,
        input  face_valid,
        input  winner,
        input  busy
    );

    modport slave (
        input  req,
        output ack,
        output face,
        output face_valid,
        output winner,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/dice_roll_arbiter.sv
// ============================================================================
// Module      : dice_roll_arbiter
// Description : Round-robin shared dice-face counter, LFSR-driven roll length.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dice_roll_arbiter #(
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int unsigned MIN_STEPS = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dice_roll_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_MIN_STEPS = 5'(MIN_STEPS);

    state_t     r_state;
    logic [7:0] r_lfsr;
    logic [2:0] r_face;
    logic [4:0] r_steps;
    logic       r_grant;
    logic       r_winner;
    logic [1:0] r_ack;
    logic       r_face_valid;
    logic       r_busy;

    logic       w_lfsr_fb;
    logic       w_pick;
    logic [2:0] w_face_next;
    logic [4:0] w_steps_init;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_steps_init = c_MIN_STEPS + {1'b0, r_lfsr[3:0]};

    always_comb begin
        w_pick = 1'b0;
        if (bus.req == 2'b11) begin
            w_pick = ~r_winner;
        end else begin
            w_pick = bus.req[1];
        end
    end

    always_comb begin
        w_face_next = 3'd1;
        case (r_face)
            3'd1:    w_face_next = 3'd6;
            3'd6:    w_face_next = 3'd2;
            3'd2:    w_face_next = 3'd3;
            3'd3:    w_face_next = 3'd4;
            3'd4:    w_face_next = 3'd5;
            default: w_face_next = 3'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_face       <= 3'd1;
            r_steps      <= 5'd0;
            r_grant      <= 1'b0;
            r_winner     <= 1'b1;
            r_ack        <= 2'b00;
            r_face_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            case (r_state)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_grant <= w_pick;
                        r_steps <= w_steps_init;
                        r_busy  <= 1'b1;
                        r_state <= S_ROLL;
                    end
                end
                S_ROLL: begin
                    // Withdrawal by the granted requester discards the roll as-is
                    if (!bus.req[r_grant]) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_face  <= w_face_next;
                        r_steps <= r_steps - 5'd1;
                        if (r_steps == 5'd1) begin
                            r_ack        <= r_grant ? 2'b10 : 2'b01;
                            r_face_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_ack        <= 2'b00;
                    r_face_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_winner     <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_ack        <= 2'b00;
                    r_face_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.face       = r_face;
    assign bus.face_valid = r_face_valid;
    assign bus.winner     = r_winner;
    assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_arbiter.sv
// ============================================================================
// Module      : tb_dice_roll_arbiter
// Description : Randomized bench with a transaction-level roll model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dice_roll_arbiter;

    localparam logic [7:0] c_SEED = 8'hA5;
    localparam int         c_MIN  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    dice_roll_arbiter_if bus ();
    dice_roll_arbiter_if bus2 ();

    dice_roll_arbiter #(.LFSR_SEED(c_SEED), .MIN_STEPS(c_MIN)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dice_roll_arbiter #(.LFSR_SEED(8'h10), .MIN_STEPS(1)) u_dut_min (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: a roll is a transaction (start cycle, length, start face index)
    int         SEQ [6] = '{1, 6, 2, 3, 4, 5};
    int         cyc   = 0;
    bit         m_act = 1'b0;
    int         m_t0  = 0;
    int         m_n   = 0;
    int         m_idx0 = 0;
    int         m_idx = 0;
    int         m_g   = 0;
    int         m_win = 1;
    logic [7:0] m_lfsr = c_SEED;

    always @(posedge clk) begin : model
        int         e;
        logic [1:0] r;
        r = bus.req;
        e = cyc - m_t0;
        if (reset) begin
            m_act  <= 1'b0;
            m_idx  <= 0;
            m_win  <= 1;
            m_lfsr <= c_SEED;
        end else begin
            if (!m_act) begin
                if (r != 2'b00) begin
                    m_g    <= (r == 2'b11) ? (1 - m_win) : (r[1] ? 1 : 0);
                    m_t0   <= cyc;
                    m_n    <= c_MIN + int'(m_lfsr & 8'h0F);
                    m_idx0 <= m_idx;
                    m_act  <= 1'b1;
                end
            end else if (e <= m_n) begin
                if (!r[m_g]) begin
                    m_act <= 1'b0;
                    m_idx <= (m_idx0 + e - 1) % 6;
                end
            end else begin
                m_act <= 1'b0;
                m_idx <= (m_idx0 + m_n) % 6;
                m_win <= m_g;
            end
            m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin : compare
        int e;
        int e_face;
        int e_ack;
        int e_fv;
        int e_busy;
        if (chk_on) begin
            e_ack = 0; e_fv = 0; e_busy = 0;
            e_face = SEQ[m_idx];
            if (m_act) begin
                e = cyc - m_t0;
                e_busy = 1;
                if (e <= m_n) begin
                    e_face = SEQ[(m_idx0 + e - 1) % 6];
                end else begin
                    e_face = SEQ[(m_idx0 + m_n) % 6];
                    e_ack  = 1 << m_g;
                    e_fv   = 1;
                end
                if (bus.ack != 2'b00) chk("ack_latency", cyc - m_t0, m_n + 1);
            end
            chk("ack", int'(bus.ack), e_ack);
            chk("face", int'(bus.face), e_face);
            chk("face_valid", int'(bus.face_valid), e_fv);
            chk("busy", int'(bus.busy), e_busy);
            chk("winner", int'(bus.winner), m_win);
            chk("face_range", int'(bus.face >= 3'd1 && bus.face <= 3'd6), 1);
        end
    end

    task automatic do_reset(input logic [1:0] r1, input logic [1:0] r2);
        reset    = 1'b1;
        bus.req  = 2'b00;
        bus2.req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.req  = r1;
        bus2.req = r2;
    endtask

    // Called in the cycle where requester 0 alone presents; checks that cycle and the roll
    task automatic measure1(input string nm, input int exp_lat, input int exp_face);
        int         lat = -1;
        int         bc  = 0;
        logic [1:0] a   = 2'b00;
        logic [2:0] f   = 3'd0;
        logic       fv  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk({nm, "_t0_face"}, int'(bus.face), 1);
                chk({nm, "_t0_busy"}, int'(bus.busy), 0);
                chk({nm, "_t0_ack"}, int'(bus.ack), 0);
                chk({nm, "_t0_winner"}, int'(bus.winner), 1);
            end
            if (bus.busy) bc++;
            if (bus.ack != 2'b00 && lat < 0) begin
                lat = k; a = bus.ack; f = bus.face; fv = bus.face_valid;
            end
            @(posedge clk);
            #1;
            if (lat == k) bus.req = 2'b00;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_ack"}, int'(a), 1);
        chk({nm, "_face"}, int'(f), exp_face);
        chk({nm, "_face_valid"}, int'(fv), 1);
        chk({nm, "_busy_cycles"}, bc, exp_lat);
    endtask

    initial begin
        int         lat2;
        int         n;
        int         rolls;
        bit         both;
        bit         seen;
        logic [1:0] a;
        logic [1:0] r;
        logic [2:0] f2;
        logic [1:0] a2;
        logic [1:0] order [4];

        bus.req  = 2'b00;
        bus2.req = 2'b00;

        // Seed A5: 4+5 = 9 advances from face 1 lands on 3
        do_reset(2'b01, 2'b00);
        chk_on = 1'b1;
        measure1("first_roll", 10, 3);

        // MIN_STEPS=1 with seed low nibble 0: single advance 1 -> 6
        do_reset(2'b00, 2'b01);
        lat2 = -1; a2 = 2'b00; f2 = 3'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus2.ack != 2'b00 && lat2 < 0) begin
                lat2 = k; a2 = bus2.ack; f2 = bus2.face;
            end
            @(posedge clk);
            #1;
            if (lat2 == k) bus2.req = 2'b00;
        end
        chk("min1_latency", lat2, 2);
        chk("min1_ack", int'(a2), 1);
        chk("min1_face", int'(f2), 6);

        // Both requesting continuously: grants alternate starting with 0
        do_reset(2'b11, 2'b00);
        n = 0; both = 1'b0;
        for (int k = 0; k < 200 && n < 4; k++) begin
            @(negedge clk);
            if (bus.ack == 2'b11) both = 1'b1;
            if (bus.ack != 2'b00) begin
                order[n] = bus.ack;
                n++;
            end
            @(posedge clk);
            #1;
        end
        bus.req = 2'b00;
        chk("b2b_count", n, 4);
        for (int i = 0; i < 4 && i < n; i++) chk("b2b_order", int'(order[i]), (i % 2 == 0) ? 1 : 2);
        chk("b2b_both_ack", int'(both), 0);

        // Requester 0 withdraws in its third ROLL cycle (face 2 after 1->6->2)
        do_reset(2'b11, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        bus.req = 2'b10;
        @(negedge clk);
        chk("abort_cycle_busy", int'(bus.busy), 1);
        chk("abort_cycle_face", int'(bus.face), 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_ack", int'(bus.ack), 0);
        chk("abort_winner", int'(bus.winner), 1);
        chk("abort_face", int'(bus.face), 2);
        seen = 1'b0; a = 2'b00;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.ack != 2'b00) begin
                seen = 1'b1; a = bus.ack;
            end
        end
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        chk("abort_then_other_ack", int'(a), 2);

        // Reset in mid-roll, then a fresh roll must repeat the seed-A5 result
        bus.req = 2'b01;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus.busy;
            @(posedge clk);
            #1;
        end
        chk("midroll_started", int'(seen), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        measure1("reset_midroll", 10, 3);

        // Random requesters, following the drop-after-ack protocol
        rolls = 0;
        for (int c = 0; c < 60000 && rolls < 1000; c++) begin
            @(negedge clk);
            a = bus.ack;
            if (a != 2'b00) rolls++;
            @(posedge clk);
            #1;
            r = bus.req;
            for (int i = 0; i < 2; i++) begin
                if (a[i])       r[i] = 1'b0;
                else if (!r[i]) r[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 99) == 0) r[i] = 1'b0;
            end
            bus.req = r;
        end
        chk("random_rolls", rolls, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
